// File: rtl/invertion_arbiter.sv
// Round-robin arbiter feeding one shared, registered inversion datapath.
// Serves one request at a time and returns the result tagged with the requester index.
module invertion_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output logic [15:0]              done_count,
  output logic [1:0]               state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready is one-hot and only asserted in IDLE; rsp_data/rsp_id hold while rsp_valid && !rsp_ready.

  localparam int SLOTS = 1 << ID_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   next_ptr;
  logic              grant_found;
  logic [SLOTS-1:0]  valid_ext;
  logic [ID_W:0]     probe;
  logic [WIDTH-1:0]  win_data;
  logic [WIDTH-1:0]  cap_data;
  logic [ID_W-1:0]   cap_id;
  logic [WIDTH-1:0]  dp_q;

  function automatic logic [31:0] invert_xform(input logic [31:0] a);
    invert_xform[31:16] = (a[31:16] == a[15:0]) ? ~a[15:0] : a[31:16];
    invert_xform[15:8]  = a[31:24] ^ a[23:16];
    invert_xform[7:0]   = ~a[7:0] | ~a[15:8];
  endfunction

  // Search starts at rr_ptr and wraps; rr_ptr < NUM_REQ so one subtraction suffices.
  always_comb begin
    valid_ext   = SLOTS'(req_valid);
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (probe >= (ID_W+1)'(NUM_REQ)) probe = probe - (ID_W+1)'(NUM_REQ);
      if (!grant_found && valid_ext[probe[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = probe[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) win_data = req_data[i*WIDTH +: WIDTH];
      req_ready[i] = (state == IDLE) && grant_found && (grant_idx == ID_W'(i));
    end
  end

  assign next_ptr  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  assign rsp_data  = dp_q;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cap_data   <= '0;
      cap_id     <= '0;
      dp_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      busy       <= 1'b0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cap_data <= win_data;
            cap_id   <= grant_idx;
            rr_ptr   <= next_ptr;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          dp_q      <= invert_xform(cap_data);
          rsp_valid <= 1'b1;
          rsp_id    <= cap_id;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            done_count <= done_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_invertion_arbiter.sv
// Bench for invertion_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_invertion_arbiter;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;
  logic [15:0]              done_count;
  logic [1:0]               state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: m_age = -1 when idle, else cycles since the accept.
  int               m_ptr = 0;
  int               m_age = -1;
  logic [15:0]      m_done = '0;
  logic [WIDTH-1:0] exp_q[$];
  int               id_q[$];

  invertion_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
    .done_count(done_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] t_ref(input logic [31:0] a);
    logic [7:0] b3, b2, b1, b0;
    logic [15:0] hi, lo;
    {b3, b2, b1, b0} = a;
    hi = {b3, b2};
    lo = {b1, b0};
    return {(hi == lo) ? ~lo : hi, b3 ^ b2, ~b0 | ~b1};
  endfunction

  function automatic int m_winner();
    if (m_age >= 0) return -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] m_ready_exp();
    int w;
    w = m_winner();
    return (w >= 0) ? NUM_REQ'(1 << w) : '0;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_age = -1; m_done = '0;
    exp_q.delete(); id_q.delete();
  endtask

  // Advances the model across the coming rising edge using the inputs now driven.
  task automatic m_advance();
    int w;
    w = m_winner();
    if (m_age < 0) begin
      if (w >= 0) begin
        m_age = 1;
        exp_q.push_back(t_ref(req_data[w*WIDTH +: WIDTH]));
        id_q.push_back(w);
        m_ptr = (w + 1) % NUM_REQ;
      end
    end else if (m_age >= 2 && rsp_ready) begin
      m_age = -1;
      void'(exp_q.pop_front());
      void'(id_q.pop_front());
      m_done = m_done + 16'd1;
    end else begin
      m_age++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = '0; rsp_ready = 1'b1;
      #1;
      m_advance();
    end
  endtask

  task automatic send_one(input int id, input logic [31:0] d, output logic [31:0] got_d,
                          output logic [ID_W-1:0] got_id, output int lat, output bit to);
    int t0;
    bit acc;
    to = 1'b1; lat = 0; got_d = '0; got_id = '0; acc = 1'b0; t0 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      if (!acc) begin
        req_valid = NUM_REQ'(1) << id;
        req_data[id*WIDTH +: WIDTH] = d;
      end else begin
        req_valid = '0;
      end
      #1;
      if (!acc && req_ready[id]) begin
        acc = 1'b1; t0 = cyc;
      end else if (acc && rsp_valid) begin
        got_d = rsp_data; got_id = rsp_id; lat = cyc - t0; to = 1'b0;
        m_advance();
        break;
      end
      m_advance();
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    #1;
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests++; if (rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    tests++; if (rsp_id !== '0) begin fails++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done_count !== 16'h0) begin fails++; $display("FAIL reset_done_count got=%h exp=0", done_count); end
    tests++; if (state_dbg !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    m_advance();
  endtask

  task automatic test_single(input int id, input logic [31:0] d, input logic [31:0] exp_d);
    logic [31:0] got_d;
    logic [ID_W-1:0] got_id;
    int lat;
    bit to;
    send_one(id, d, got_d, got_id, lat, to);
    tests++; if (to) begin fails++; $display("FAIL single_timeout id=%0d got=timeout exp=response", id); end
    tests++; if (got_d !== exp_d) begin fails++; $display("FAIL single_data id=%0d got=%h exp=%h", id, got_d, exp_d); end
    tests++; if (got_id !== ID_W'(id)) begin fails++; $display("FAIL single_id got=%0d exp=%0d", got_id, id); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL single_latency got=%0d exp=2", lat); end
    @(negedge clk);
    req_valid = '0;
    #1;
    tests++; if (done_count !== m_done) begin fails++; $display("FAIL single_done_count got=%h exp=%h", done_count, m_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after got=%b exp=0", busy); end
    m_advance();
  endtask

  task automatic test_fairness();
    int count, last, idx;
    do_reset();
    count = 0; last = 0;
    for (int n = 0; n < 60 && count < 12; n++) begin
      @(negedge clk);
      req_valid = '1; rsp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
      #1;
      if (rsp_valid && m_age >= 2) begin
        tests++;
        if (rsp_data !== exp_q[0]) begin fails++; $display("FAIL fair_rsp_data got=%h exp=%h", rsp_data, exp_q[0]); end
      end
      if ((req_ready & req_valid) != '0) begin
        idx = count % NUM_REQ;
        tests++;
        if (req_ready !== NUM_REQ'(1 << idx)) begin fails++; $display("FAIL fair_grant n=%0d got=%b exp=%b", count, req_ready, NUM_REQ'(1 << idx)); end
        if (count > 0) begin
          tests++;
          if (cyc - last !== 3) begin fails++; $display("FAIL fair_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        count++;
      end
      m_advance();
    end
    tests++; if (count !== 12) begin fails++; $display("FAIL fair_accept_count got=%0d exp=12", count); end
    idle_cycles(4);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ready = (n >= 7);
      #1;
      if (n == 0 || n == 8) begin
        tests++;
        if (req_ready !== m_ready_exp() || req_ready !== NUM_REQ'(n == 0 ? 1 : 2)) begin
          fails++; $display("FAIL bp_accept n=%0d got=%b exp=%b", n, req_ready, NUM_REQ'(n == 0 ? 1 : 2));
        end
      end
      if (n >= 2 && n <= 6) begin
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_q[0] || rsp_id !== ID_W'(id_q[0]) || req_ready !== '0) begin
          fails++;
          $display("FAIL bp_hold n=%0d got=v%b d=%h id=%0d rdy=%b exp=v1 d=%h id=%0d rdy=0",
                   n, rsp_valid, rsp_data, rsp_id, req_ready, exp_q[0], id_q[0]);
        end
      end
      m_advance();
    end
    idle_cycles(5);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      req_valid = '1; rsp_ready = 1'b1;
      #1;
      m_advance();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL rstmid_exec_ready got=%b exp=0", req_ready); end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || busy !== 1'b0 || done_count !== m_done) begin
      fails++;
      $display("FAIL rstmid_outputs got=v%b d=%h id=%0d busy=%b cnt=%h exp=all zero",
               rsp_valid, rsp_data, rsp_id, busy, done_count);
    end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rstmid_grant got=%b exp=0001", req_ready); end
    m_advance();
    @(negedge clk);
    req_valid = '0;
    #1;
    m_advance();
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(id_q[0]) || rsp_data !== exp_q[0]) begin
      fails++; $display("FAIL rstmid_after got=v%b id=%0d d=%h exp=v1 id=%0d d=%h", rsp_valid, rsp_id, rsp_data, id_q[0], exp_q[0]);
    end
    m_advance();
    idle_cycles(3);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] exp_rdy;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = m_ready_exp();
      tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rand_req_ready n=%0d got=%b exp=%b", n, req_ready, exp_rdy); end
      tests++; if (rsp_valid !== (m_age >= 2)) begin fails++; $display("FAIL rand_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, m_age >= 2); end
      tests++; if (busy !== (m_age >= 0)) begin fails++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_age >= 0); end
      tests++; if (done_count !== m_done) begin fails++; $display("FAIL rand_done_count n=%0d got=%h exp=%h", n, done_count, m_done); end
      if (m_age >= 2) begin
        tests++;
        if (rsp_data !== exp_q[0] || rsp_id !== ID_W'(id_q[0])) begin
          fails++; $display("FAIL rand_rsp n=%0d got=%h/%0d exp=%h/%0d", n, rsp_data, rsp_id, exp_q[0], id_q[0]);
        end
      end
      m_advance();
    end
    idle_cycles(4);
  endtask

  task automatic test_counter_wrap();
    logic [31:0] got_d;
    logic [ID_W-1:0] got_id;
    int lat;
    bit to;
    @(negedge clk);
    req_valid = '0;
    force dut.done_count = 16'hFFFD;
    #1;
    release dut.done_count;
    m_done = 16'hFFFD;
    for (int k = 0; k < 3; k++) begin
      send_one(k, $urandom, got_d, got_id, lat, to);
      tests++; if (to) begin fails++; $display("FAIL wrap_timeout k=%0d got=timeout exp=response", k); end
      @(negedge clk);
      req_valid = '0;
      #1;
      tests++; if (done_count !== m_done) begin fails++; $display("FAIL wrap_done_count k=%0d got=%h exp=%h", k, done_count, m_done); end
      m_advance();
    end
  endtask

  initial begin
    test_reset();
    test_single(2, 32'h12345678, 32'h123426AF);
    test_single(0, 32'hABCDABCD, 32'h54326676);
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/invertion_arbiter.md
# invertion_arbiter

Round-robin arbiter and sequencer that shares one registered inversion datapath between `NUM_REQ` requesters. It accepts one request at a time over a valid/ready handshake and drives the captured word through the datapath. It returns the result tagged with the requester index over a valid/ready response port. It sits between the random-design stimulus sources and the shared transform, replacing per-source copies of the datapath.

## Interface
- `WIDTH`, 32, data word width; only 32 is supported and the transform bit-slicing requires it.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `ID_W`, 3, width of requester index; must satisfy 2**ID_W >= NUM_REQ.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_data` in NUM_REQ*WIDTH: request words; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready` out NUM_REQ: one-hot accept; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out WIDTH: transformed word.
- `rsp_id` out ID_W: index of the requester that owns `rsp_data`.
- `busy` out 1: high whenever state is not IDLE.
- `done_count` out 16: count of completed responses; wraps 0xFFFF->0x0000.

## Operation
- Transform T(a), 32 bits:
  - [31:16] = (a[31:16]==a[15:0]) ? ~a[15:0] : a[31:16]
  - [15:8] = a[31:24]^a[23:16]
  - [7:0] = ~a[7:0] | ~a[15:8]
- Datapath is registered: its output appears one cycle after its input is presented.
- FSM states:
  - IDLE: arbitrate. If any `req_valid` is set, raise `req_ready` for the winner only. Capture `req_data` slice and index into `cap_data`/`cap_id`, then go to EXEC.
  - EXEC: `cap_data` is at the datapath input for one cycle, then go to HOLD.
  - HOLD: `rsp_valid`=1, `rsp_data`=datapath output, `rsp_id`=`cap_id`. On `rsp_ready`, increment `done_count` and go to IDLE; otherwise stay in HOLD.
- Arbitration is round-robin. Pointer `rr_ptr` (reset 0) names the highest-priority requester. Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
- After a grant to i, `rr_ptr` = (i+1) mod NUM_REQ. `rr_ptr` is unchanged when there is no grant.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and state. It is all-zero outside IDLE and all-zero when no valid is set.
- `rsp_data`/`rsp_id` hold stable while `rsp_valid` && !`rsp_ready`.
- A requester dropping `req_valid` without a transfer is legal and is simply not granted.
- Only one transaction is in flight; there is no queuing.

## Timing
- Reset values: state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `done_count`=0, `rr_ptr`=0. The datapath register is cleared.
- Accept at cycle T gives `rsp_valid` high from cycle T+2.
- With `rsp_ready` held high, the response handshake is at T+2, the FSM is back in IDLE at T+3, and the next accept is at T+3. Peak throughput is one word per 3 cycles.
- A `rsp_ready` stall of k cycles delays the next accept by k cycles.
- `done_count` updates the cycle after the response handshake.
- `rst` asserted in any state aborts the in-flight transaction: no response is produced and all reset values are applied next cycle. `rr_ptr` also returns to 0.
- Simultaneous valids are resolved by `rr_ptr` alone; there is no fixed priority.
- A request whose valid rises while the FSM is in EXEC/HOLD waits with `req_ready`=0 until IDLE.

## Test plan
- Single request: requester 2 sends 0x12345678, `rsp_ready`=1 -> `rsp_valid` at T+2 with `rsp_data`=0x123426AF, `rsp_id`=2, `done_count`=1.
- Equal-halves case: requester 0 sends 0xABCDABCD -> `rsp_data`=0x54326676, `rsp_id`=0.
- Fairness: all 4 valids held high for 12 accepts -> grant order 0,1,2,3,0,1,... with accepts spaced exactly 3 cycles apart.
- Back-pressure: `rsp_ready`=0 for 5 cycles in HOLD -> `rsp_valid`, `rsp_data` and `rsp_id` stay stable, all `req_ready`=0, and the next accept is delayed 5 cycles.
- Reset mid-operation: `rst` pulsed in EXEC -> no response is emitted, all outputs return to reset values, and the next grant with all valids set goes to requester 0.
- Counter wrap: preload via 65536 transactions (or force) -> `done_count` reads 0x0000 after the 65536th handshake.
